// File: rtl/zero_count_seq_pkg.sv
// Purpose: shared types and constants for the sequential zero counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scan FSM state enum and the mode encodings carried on the mode line.
package zc_pkg;

    typedef enum logic {
        ZC_IDLE = 1'b0,
        ZC_SCAN = 1'b1
    } zc_state_t;

    localparam logic ZC_TRAIL = 1'b0;
    localparam logic ZC_LEAD  = 1'b1;

endpackage : zc_pkg

// File: rtl/zero_count_seq_if.sv
// Purpose: request/result bundle between a client and zero_count_seq.
// Latency: n/a (wiring only).
// Backpressure: start is ignored while busy is high; there is no queuing.
// Signals: start/mode/din from the client; busy/done/count/all_zero back to it.
interface zero_count_seq_if #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;
    logic             all_zero;

    // Client side: issues requests, observes results.
    modport master (
        output start, mode, din,
        input  busy, done, count, all_zero
    );

    // Counter side: accepts requests, produces results.
    modport slave (
        input  start, mode, din,
        output busy, done, count, all_zero
    );
endinterface : zero_count_seq_if

// File: rtl/zero_count_seq_first_one.sv
// Purpose: combinational priority encoder returning the lowest set bit of a chunk.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_chunk operand; o_found = any bit set; o_pos = index of lowest set bit (0 when none).
module zc_first_one #(
    parameter int CHUNK = 4,
    parameter int PW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] i_chunk,
    output logic             o_found,
    output logic [PW-1:0]    o_pos
);

    always_comb begin
        o_found = |i_chunk;
        o_pos   = '0;
        // Walk from the top down so the lowest set bit is the last one written.
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (i_chunk[i]) begin
                o_pos = PW'(i);
            end
        end
    end

endmodule : zc_first_one

// File: rtl/zero_count_seq.sv
// Purpose: multi-cycle leading/trailing zero counter, CHUNK bits examined per clock.
// Latency: done 1..WIDTH/CHUNK cycles after start is accepted (chunk holding the first 1, plus one).
// Backpressure: start accepted only while idle; start during a scan is dropped.
// Ports: clk, rst (async active-high); bus (slave modport) carries start/mode/din and busy/done/count/all_zero.
module zero_count_seq
    import zc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    zero_count_seq_if.slave   bus
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int PW  = $clog2(CHUNK + 1);
    localparam int NCH = WIDTH / CHUNK;
    localparam int JW  = (NCH > 1) ? $clog2(NCH) : 1;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
        $fatal(1, "zero_count_seq: WIDTH must be a positive multiple of CHUNK");
    end

    zc_state_t        r_state;
    logic [WIDTH-1:0] r_word;
    logic [JW-1:0]    r_j;
    logic [CW-1:0]    r_acc;
    logic             r_done;
    logic [CW-1:0]    r_count;
    logic             r_all_zero;

    zc_state_t        w_state_nxt;
    logic [JW-1:0]    w_j_nxt;
    logic [CW-1:0]    w_acc_nxt;
    logic             w_done_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_all_zero_nxt;
    logic             w_capture;
    logic [WIDTH-1:0] w_din_rev;
    logic [WIDTH-1:0] w_word_in;
    logic [CHUNK-1:0] w_chunk;
    logic             w_found;
    logic [PW-1:0]    w_pos;
    logic             w_last;

    // Leading mode is turned into trailing mode by reversing the operand once at
    // capture; the scan itself then always walks up from bit 0.
    always_comb begin
        w_din_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_din_rev[i] = bus.din[WIDTH-1-i];
        end
    end

    assign w_word_in = (bus.mode == ZC_LEAD) ? w_din_rev : bus.din;
    assign w_chunk   = CHUNK'(r_word >> (int'(r_j) * CHUNK));
    assign w_last    = (r_j == JW'(NCH - 1));

    zc_first_one #(
        .CHUNK (CHUNK),
        .PW    (PW)
    ) u_first_one (
        .i_chunk (w_chunk),
        .o_found (w_found),
        .o_pos   (w_pos)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_j_nxt        = r_j;
        w_acc_nxt      = r_acc;
        w_done_nxt     = 1'b0;
        w_count_nxt    = r_count;
        w_all_zero_nxt = r_all_zero;
        w_capture      = 1'b0;
        case (r_state)
            ZC_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ZC_SCAN;
                    w_j_nxt     = '0;
                    w_acc_nxt   = '0;
                    w_capture   = 1'b1;
                end
            end
            ZC_SCAN: begin
                if (w_found) begin
                    w_count_nxt    = r_acc + CW'(w_pos);
                    w_all_zero_nxt = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = ZC_IDLE;
                end else if (w_last) begin
                    w_count_nxt    = CW'(WIDTH);
                    w_all_zero_nxt = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = ZC_IDLE;
                end else begin
                    // acc tops out at WIDTH-CHUNK here, so CW bits never overflow.
                    w_acc_nxt = r_acc + CW'(CHUNK);
                    w_j_nxt   = r_j + JW'(1);
                end
            end
            default: w_state_nxt = ZC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ZC_IDLE;
            r_word     <= '0;
            r_j        <= '0;
            r_acc      <= '0;
            r_done     <= 1'b0;
            r_count    <= '0;
            r_all_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_j        <= w_j_nxt;
            r_acc      <= w_acc_nxt;
            r_done     <= w_done_nxt;
            r_count    <= w_count_nxt;
            r_all_zero <= w_all_zero_nxt;
            if (w_capture) begin
                r_word <= w_word_in;
            end
        end
    end

    assign bus.busy     = (r_state == ZC_SCAN);
    assign bus.done     = r_done;
    assign bus.count    = r_count;
    assign bus.all_zero = r_all_zero;

endmodule : zero_count_seq

// File: tb/tb_zero_count_seq.sv
// Purpose: directed self-checking bench for zero_count_seq at WIDTH=16, CHUNK=4.
// Latency: inputs driven between edges, outputs sampled 1 time unit after rising edges.
// Backpressure: exercises dropped starts during a scan and back-to-back starts on done.
module tb_zero_count_seq;
    import zc_pkg::*;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    zero_count_seq_if #(.WIDTH(WIDTH)) bus ();

    zero_count_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raises start with the given operand, lets one edge accept it, and then
    // counts edges until done (sampled 1 unit after each edge). busy_cyc counts
    // samples with busy high from the acceptance edge up to done. lat = 0 means
    // done never arrived within the budget.
    task automatic run_op(input logic [WIDTH-1:0] d, input logic m,
                          output int lat, output int busy_cyc);
        bus.start = 1'b1;
        bus.din   = d;
        bus.mode  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat      = 0;
        busy_cyc = bus.busy ? 1 : 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.busy) busy_cyc++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
        end
        #2;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = ZC_TRAIL;
        bus.din   = '0;
        idle_cycles(2);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== '0 || bus.all_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b done=%b count=%0d all_zero=%b, want 0 0 0 0",
                     bus.busy, bus.done, bus.count, bus.all_zero);
        end
        rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_trail_first_chunk;
        int lat, bc;
        run_op(16'h0008, ZC_TRAIL, lat, bc);
        n_checks++;
        if (lat !== 1 || bus.count !== CW'(3) || bus.all_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL trail_0008: lat=%0d count=%0d az=%b, want lat=1 count=3 az=0",
                     lat, bus.count, bus.all_zero);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.count !== CW'(3)) begin
            n_errors++;
            $display("FAIL done_pulse_width: done=%b count=%0d, want done=0 count=3 held",
                     bus.done, bus.count);
        end
        idle_cycles(2);
    endtask

    task automatic test_trail_third_chunk;
        int lat, bc;
        run_op(16'h0100, ZC_TRAIL, lat, bc);
        n_checks++;
        if (lat !== 3 || bus.count !== CW'(8)) begin
            n_errors++;
            $display("FAIL trail_0100: lat=%0d count=%0d, want lat=3 count=8", lat, bus.count);
        end
        n_checks++;
        if (bc !== 3 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_window: busy_cycles=%0d busy_at_done=%b, want 3 and 0", bc, bus.busy);
        end
        idle_cycles(2);
    endtask

    task automatic test_all_zero;
        int lat, bc;
        run_op(16'h0000, ZC_TRAIL, lat, bc);
        n_checks++;
        if (lat !== 4 || bus.count !== CW'(16) || bus.all_zero !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_trail: lat=%0d count=%0d az=%b, want lat=4 count=16 az=1",
                     lat, bus.count, bus.all_zero);
        end
        idle_cycles(2);
        run_op(16'h0000, ZC_LEAD, lat, bc);
        n_checks++;
        if (lat !== 4 || bus.count !== CW'(16) || bus.all_zero !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_lead: lat=%0d count=%0d az=%b, want lat=4 count=16 az=1",
                     lat, bus.count, bus.all_zero);
        end
        idle_cycles(2);
    endtask

    task automatic test_lead;
        int lat, bc;
        run_op(16'h0F00, ZC_LEAD, lat, bc);
        n_checks++;
        if (lat !== 2 || bus.count !== CW'(4) || bus.all_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL lead_0F00: lat=%0d count=%0d az=%b, want lat=2 count=4 az=0",
                     lat, bus.count, bus.all_zero);
        end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        run_op(16'h8001, ZC_LEAD, lat, bc);
        n_checks++;
        if (lat !== 1 || bus.count !== CW'(0) || bus.all_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL lead_8001: lat=%0d count=%0d az=%b, want lat=1 count=0 az=0",
                     lat, bus.count, bus.all_zero);
        end
        // Reissue in the done cycle itself.
        run_op(16'h8001, ZC_TRAIL, lat, bc);
        n_checks++;
        if (lat !== 1 || bus.count !== CW'(0) || bc !== 1) begin
            n_errors++;
            $display("FAIL b2b_trail_8001: lat=%0d count=%0d busy_cycles=%0d, want lat=1 count=0 busy=1",
                     lat, bus.count, bc);
        end
        idle_cycles(2);
    endtask

    task automatic test_start_ignored;
        int lat;
        lat = 0;
        bus.start = 1'b1;
        bus.din   = 16'h0000;
        bus.mode  = ZC_TRAIL;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        // Second request mid-scan, with a different operand and mode.
        bus.start = 1'b1;
        bus.din   = 16'h0001;
        bus.mode  = ZC_LEAD;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 3; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat !== 4 || bus.count !== CW'(16) || bus.all_zero !== 1'b1) begin
            n_errors++;
            $display("FAIL start_ignored: lat=%0d count=%0d az=%b, want lat=4 count=16 az=1",
                     lat, bus.count, bus.all_zero);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL no_queued_op: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_scan;
        int saw_done, lat, bc;
        saw_done = 0;
        bus.start = 1'b1;
        bus.din   = 16'h0000;
        bus.mode  = ZC_TRAIL;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== '0 || bus.all_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: busy=%b done=%b count=%0d az=%b, want 0 0 0 0",
                     bus.busy, bus.done, bus.count, bus.all_zero);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done++;
        end
        n_checks++;
        if (saw_done !== 0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL aborted_scan: done_pulses=%0d busy=%b, want 0 0", saw_done, bus.busy);
        end
        run_op(16'h0010, ZC_TRAIL, lat, bc);
        n_checks++;
        if (lat !== 2 || bus.count !== CW'(4) || bus.all_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL after_reset_0010: lat=%0d count=%0d az=%b, want lat=2 count=4 az=0",
                     lat, bus.count, bus.all_zero);
        end
        idle_cycles(2);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_trail_first_chunk();
        test_trail_third_chunk();
        test_all_zero();
        test_lead();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_zero_count_seq
